// File: rtl/codificador_pt2262.sv
// PT2262-style remote-control encoder.
// Serialises an 8-bit address and 4-bit data word as twelve pulse-width
// coded bits followed by a long sync bit, repeated back to back. Timing is
// derived from an internal oscillator that is a divided copy of clk; every
// register runs on clk and advances one step on each oscillator rising edge.

module codificador_pt2262 #(
  parameter int OSC_HALF = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] A,
  input  logic [3:0] D,
  output logic       sync,
  output logic       cod_o
);

  localparam int DIV_W = (OSC_HALF > 1) ? $clog2(OSC_HALF) : 1;

  localparam logic [6:0] SYNC_LAST_TICK = 7'd127;
  localparam logic [6:0] BIT_LAST_TICK  = 7'd31;
  localparam logic [3:0] LAST_BIT       = 4'd11;
  localparam logic [6:0] SYNC_HIGH      = 7'd4;
  localparam logic [3:0] SHORT_HIGH     = 4'd4;
  localparam logic [3:0] LONG_HIGH      = 4'd12;

  typedef enum logic {
    SYNC,
    DATA
  } state_t;

  logic [DIV_W-1:0] div_cnt;
  logic             div_end;
  logic             osc_clk;
  logic             tick;

  state_t           state;
  state_t           state_nxt;
  logic [6:0]       tick_cnt;
  logic [6:0]       tick_nxt;
  logic [3:0]       bit_cnt;
  logic [3:0]       bit_nxt;
  logic [11:0]      word;
  logic [11:0]      word_nxt;
  logic             sync_nxt;
  logic             cod_nxt;

  logic [3:0]       phase;
  logic [3:0]       bit_idx;
  logic             cur_bit;

  assign div_end = (div_cnt == DIV_W'(OSC_HALF - 1));

  // A tick is the clk cycle in which osc_clk is about to go from 0 to 1.
  assign tick = div_end & ~osc_clk;

  // Oscillator divider: osc_clk toggles once every OSC_HALF clk cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      osc_clk <= 1'b0;
    end else if (div_end) begin
      div_cnt <= '0;
      osc_clk <= ~osc_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Position inside a 16-tick pulse cycle and the code bit being sent (MSB first).
  assign phase   = tick_cnt[3:0];
  assign bit_idx = LAST_BIT - bit_cnt;
  assign cur_bit = word[bit_idx];

  // Next position and the output level for the tick at the current position.
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    word_nxt  = word;
    sync_nxt  = 1'b0;
    cod_nxt   = 1'b0;
    case (state)
      SYNC: begin
        sync_nxt = 1'b1;
        cod_nxt  = (tick_cnt < SYNC_HIGH);
        if (tick_cnt == SYNC_LAST_TICK) begin
          state_nxt = DATA;
          tick_nxt  = '0;
          bit_nxt   = '0;
          word_nxt  = {A, D};
        end else begin
          tick_nxt = tick_cnt + 1'b1;
        end
      end
      DATA: begin
        sync_nxt = 1'b0;
        cod_nxt  = cur_bit ? (phase < LONG_HIGH) : (phase < SHORT_HIGH);
        if (tick_cnt == BIT_LAST_TICK) begin
          tick_nxt = '0;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = SYNC;
            bit_nxt   = '0;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end else begin
          tick_nxt = tick_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = SYNC;
        tick_nxt  = '0;
        bit_nxt   = '0;
      end
    endcase
  end

  // Sequencer and output registers only move on a tick, so the outputs stay
  // stable for a whole oscillator period between ticks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= SYNC;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      word     <= '0;
      sync     <= 1'b0;
      cod_o    <= 1'b0;
    end else if (tick) begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      word     <= word_nxt;
      sync     <= sync_nxt;
      cod_o    <= cod_nxt;
    end
  end

endmodule

// File: tb/tb_codificador_pt2262.sv
// Directed bench for codificador_pt2262 with OSC_HALF = 4 (one tick per 8 clk).
// Expected waveforms are built from the bench's own knowledge of the format.

module tb_codificador_pt2262;

  logic       clk;
  logic       reset;
  logic [7:0] A;
  logic [3:0] D;
  logic       sync;
  logic       cod_o;

  int total;
  int bad;
  int gap_next;
  int tick_num;
  int last_rise;

  codificador_pt2262 #(.OSC_HALF(4)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .D     (D),
    .sync  (sync),
    .cod_o (cod_o)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-bit comparison with failure accounting
  task automatic checkOutput(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Integer comparison with failure accounting
  task automatic checkCount(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next tick edge
  task automatic waitTick();
    repeat (gap_next) @(posedge clk);
    #1;
    gap_next = 8;
    tick_num++;
  endtask

  // Expect the sync bit from tick position start to 127
  task automatic runSync(input int start, input bit change_at_end, input logic [7:0] new_a);
    for (int t = start; t < 128; t++) begin
      waitTick();
      if (t == 0) begin
        if (last_rise > 0)
          checkCount("sync_spacing", tick_num - last_rise, 512);
        last_rise = tick_num;
      end
      checkOutput($sformatf("sync_t%0d_sync", t), sync, 1'b1);
      checkOutput($sformatf("sync_t%0d_cod", t), cod_o, (t < 4) ? 1'b1 : 1'b0);
    end
    if (change_at_end) A = new_a;
  endtask

  // Expect one code bit; optionally zero A partway through it
  task automatic runBit(input int idx, input logic b, input bit zero_a);
    int highs;
    logic exp;
    highs = 0;
    for (int t = 0; t < 32; t++) begin
      waitTick();
      exp = b ? ((t % 16) < 12) : ((t % 16) < 4);
      checkOutput($sformatf("bit%0d_t%0d_cod", idx, t), cod_o, exp);
      checkOutput($sformatf("bit%0d_t%0d_sync", idx, t), sync, 1'b0);
      if (cod_o === 1'b1) highs++;
      if (zero_a && t == 10) A = 8'h00;
    end
    checkCount($sformatf("bit%0d_high_time", idx), highs, b ? 24 : 8);
  endtask

  // Expect the first nbits code bits of a word
  task automatic runWord(input logic [11:0] w, input int nbits, input int zero_bit);
    for (int i = 0; i < nbits; i++)
      runBit(i, w[11 - i], (i == zero_bit));
  endtask

  // Drive inputs
  task automatic applyStimulus(input logic [7:0] a_v, input logic [3:0] d_v);
    A = a_v;
    D = d_v;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    gap_next  = 8;
    tick_num  = 0;
    last_rise = 0;
    reset     = 1'b0;
    applyStimulus(8'h00, 4'h0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_osc", dut.osc_clk, 1'b0);
    checkOutput("rst_sync", sync, 1'b0);
    checkOutput("rst_cod", cod_o, 1'b0);
    reset = 1'b1;

    // Oscillator: first rise 4 clk after release, then period 8
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pre_tick_osc", dut.osc_clk, 1'b0);
    checkOutput("pre_tick_sync", sync, 1'b0);
    checkOutput("pre_tick_cod", cod_o, 1'b0);
    gap_next = 1;
    waitTick();
    last_rise = tick_num;
    checkOutput("tick1_osc", dut.osc_clk, 1'b1);
    checkOutput("tick1_sync", sync, 1'b1);
    checkOutput("tick1_cod", cod_o, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("half_osc", dut.osc_clk, 1'b0);
    checkOutput("half_sync_hold", sync, 1'b1);
    checkOutput("half_cod_hold", cod_o, 1'b1);
    gap_next = 4;
    waitTick();
    checkOutput("tick2_osc", dut.osc_clk, 1'b1);
    checkOutput("tick2_cod", cod_o, 1'b1);

    // Word 1: A=F0, D=A set during the first sync bit
    applyStimulus(8'hF0, 4'hA);
    runSync(2, 1'b0, 8'h00);
    $display("[TB] word 1");
    runWord(12'b1111_0000_1010, 12, 3);

    // Word 2 carries the zeroed address; A changes right after capture
    runSync(0, 1'b1, 8'hFF);
    $display("[TB] word 2");
    runWord(12'b0000_0000_1010, 12, -1);

    // Word 3 = FF/A; reset two ticks into bit 6 (a long-high bit)
    runSync(0, 1'b0, 8'h00);
    $display("[TB] word 3");
    runWord(12'b1111_1111_1010, 6, -1);
    waitTick();
    waitTick();
    checkOutput("pre_reset_cod", cod_o, 1'b1);
    reset = 1'b0;
    #1;
    checkOutput("mid_reset_cod", cod_o, 1'b0);
    checkOutput("mid_reset_sync", sync, 1'b0);
    checkOutput("mid_reset_osc", dut.osc_clk, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    applyStimulus(8'h81, 4'h5);
    reset = 1'b1;
    gap_next = 4;
    last_rise = 0;

    // Fresh sync bit then word 81/5
    runSync(0, 1'b0, 8'h00);
    $display("[TB] word after reset");
    runWord(12'b1000_0001_0101, 12, -1);
    runSync(0, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/codificador_pt2262.md
CODIFICADOR_PT2262 -- requirements
Module: codificador_pt2262

Interface
REQ-001 The module SHALL have parameter OSC_HALF, default 4, giving the number of clk cycles per half period of the internal oscillator clock (osc period = 2*OSC_HALF clk cycles).
REQ-002 The module SHALL have port clk, input, 1 bit: system clock (3 MHz nominal); the only clock.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port A, input, 8 bits: address code, binary only, no float/ternary support.
REQ-005 The module SHALL have port D, input, 4 bits: data code.
REQ-006 The module SHALL have port sync, output, 1 bit: high for the whole sync-bit window of each word.
REQ-007 The module SHALL have port cod_o, output, 1 bit: PT2262-format serial code output.

Function
REQ-008 The module SHALL contain an internal 1-bit signal named osc_clk, reachable hierarchically, that toggles every OSC_HALF clk cycles.
- Reset value of osc_clk: 0.
REQ-009 All registers SHALL be clocked by clk.
- State advances by one osc step ("tick") on each clk cycle where osc_clk goes 0->1.
- No logic SHALL be clocked by osc_clk.
REQ-010 Word format SHALL be 12 code bits then 1 sync bit, repeated continuously with no gap.
- Code bit order: A[7]..A[0], then D[3]..D[0] (MSB first).
REQ-011 Each code bit SHALL last 32 ticks, made of two 16-tick pulse cycles.
- Bit 0: each pulse cycle = high 4 ticks, low 12 ticks.
- Bit 1: each pulse cycle = high 12 ticks, low 4 ticks.
REQ-012 The sync bit SHALL last 128 ticks: cod_o high 4 ticks, then low 124 ticks.
- sync = 1 for all 128 ticks of the sync bit, 0 otherwise.
REQ-013 A and D SHALL be captured into an internal 12-bit word register on the tick that ends the sync bit.
- Input changes during a word SHALL NOT affect the word in progress.
REQ-014 FSM states SHALL be SYNC and DATA.
- SYNC -> DATA after tick 128 of the sync bit; this transition performs the capture.
- DATA -> SYNC after tick 32 of bit 12.
- Bit counter 0..11; tick counter 0..31 in DATA, 0..127 in SYNC.
- Counters wrap to 0 on each state transition.
REQ-015 Total word length SHALL be 12*32 + 128 = 512 ticks.
- sync rises exactly every 512 ticks.
REQ-016 cod_o and sync SHALL be registered and change only in the clk cycle of a tick.

Reset
REQ-017 While reset = 0, the module SHALL asynchronously force:
- osc_clk = 0, cod_o = 0, sync = 0;
- oscillator divider, tick counter and bit counter = 0;
- word register = 0;
- FSM state = SYNC.
REQ-018 After reset deasserts, the first tick SHALL start a full 128-tick sync bit.
- The first data word is therefore the A/D values present at the end of that sync bit.
REQ-019 Reset asserted mid-word SHALL abort the word immediately, with no partial completion.

Verification
REQ-020 Scenario: reset pulse, OSC_HALF = 4, then count clk cycles between osc_clk rising edges -> 8 clk cycles, osc_clk = 0 during reset.
REQ-021 Scenario: release reset -> sync = 1 for ticks 1..128; cod_o high for ticks 1..4 and low for ticks 5..128.
REQ-022 Scenario: A = 8'b11110000, D = 4'b1010 applied during the first sync bit -> serial bits 1,1,1,1,0,0,0,0,1,0,1,0.
- Each 1 = two cycles of 12 high / 4 low; each 0 = two cycles of 4 high / 12 low.
- Followed by the sync bit.
REQ-023 Scenario: change A to 8'h00 during data bit 3 -> current word unchanged; the next word (after the next sync) carries all-zero address bits.
REQ-024 Scenario: run 1000 ticks -> sync rising edges exactly 512 ticks apart; cod_o high time per code bit = 8 ticks (bit 0) or 24 ticks (bit 1).
REQ-025 Scenario: assert reset during data bit 6 -> cod_o = 0 and sync = 0 immediately; after release, a fresh 128-tick sync bit precedes the data.
